// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use, multi-cycle EX ops, flush requests.
// Outputs are combinational from state and inputs, so a stall applies on the same edge as its hazard.
module pipe_hazard_ctrl #(
    parameter int BUSY_MAX = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_reg1_re_i,
    input  logic [4:0]       id_reg1_addr_i,
    input  logic             id_reg2_re_i,
    input  logic [4:0]       id_reg2_addr_i,
    input  logic             ex_is_load_i,
    input  logic             ex_wreg_i,
    input  logic [4:0]       ex_wd_i,
    input  logic             ex_multi_start_i,
    input  logic             ex_multi_done_i,
    input  logic             flush_req_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             ex_multi_cancel_o,
    output logic             busy_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int BW = $clog2(BUSY_MAX + 1);

    typedef enum logic {IDLE, EX_BUSY} state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
    logic             busy_err_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             lu;
    logic             timeout;

    always_comb begin
        lu = ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
             ((id_reg1_re_i && (id_reg1_addr_i == ex_wd_i)) ||
              (id_reg2_re_i && (id_reg2_addr_i == ex_wd_i)));
        timeout = !rst && !flush_req_i && (state_q == EX_BUSY) && !ex_multi_done_i &&
                  (busy_cnt_q == BW'(BUSY_MAX - 1));

        stall_o           = 6'b000000;
        flush_o           = 1'b0;
        ex_multi_cancel_o = 1'b0;
        state_d           = state_q;
        busy_cnt_d        = busy_cnt_q;

        if (rst) begin
            state_d    = IDLE;
            busy_cnt_d = '0;
        end else if (flush_req_i) begin
            flush_o           = 1'b1;
            ex_multi_cancel_o = (state_q == EX_BUSY);
            state_d           = IDLE;
            busy_cnt_d        = '0;
        end else if (state_q == EX_BUSY) begin
            // Done releases the stall in its own cycle so the result advances.
            if (ex_multi_done_i) begin
                state_d    = IDLE;
                busy_cnt_d = '0;
            end else if (timeout) begin
                ex_multi_cancel_o = 1'b1;
                state_d           = IDLE;
                busy_cnt_d        = '0;
            end else begin
                stall_o    = 6'b001111;
                busy_cnt_d = busy_cnt_q + BW'(1);
            end
        end else if (ex_multi_start_i) begin
            stall_o    = 6'b001111;
            state_d    = EX_BUSY;
            busy_cnt_d = '0;
        end else if (lu) begin
            // ID/EX takes a bubble; next cycle the MEM forward covers the load.
            stall_o = 6'b000111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_cnt_q  <= '0;
            busy_err_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            if (timeout) begin
                busy_err_q <= 1'b1;
            end
            if (stall_o[0] && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign busy_err_o  = busy_err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
